// File: rtl/elab_lane_fifo_if.sv
// Handshake bundle for elab_lane_fifo: push side, pop side with lane rotation.
// Lane and entry types are rebuilt here from the same parameters as the FIFO.
interface elab_lane_fifo_if #(
    parameter int LANE_W = 6,
    parameter int NLANES = 4
);
    localparam int ROT_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [NLANES-1:0] entry_t;

    logic             wr_valid;
    logic             wr_ready;
    entry_t           wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [ROT_W-1:0] rd_rot;
    entry_t           rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready, rd_rot,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready, rd_rot,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/elab_lane_fifo.sv
// Synchronous FIFO of packed lane arrays, non-power-of-2 depth, rotated head read, high-water mark.
// Optional ELAB_LANE_FIFO_BYPASS_EN: an empty FIFO forwards wr_data straight to rd_data.
module elab_lane_fifo #(
    parameter int LANE_W = 6,
    parameter int NLANES = 4,
    parameter int DEPTH  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    elab_lane_fifo_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] hwm,
    output logic [31:0]                cfg_word
);
    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [NLANES-1:0] entry_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ROT_W   = (NLANES > 1) ? $clog2(NLANES) : 1;

    localparam logic [31:0] CFG_WORD = {16'($bits(entry_t)), 8'(DEPTH), 8'(NLANES)};

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] hwm_reg;
    logic [CNT_W-1:0] count_next;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass_take;
    logic             push_mem;
    logic             pop_mem;
    logic [ROT_W-1:0] rot_amt;
    entry_t           rot_src;
    entry_t           rot_out;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

`ifdef ELAB_LANE_FIFO_BYPASS_EN
    assign bus.rd_valid = !empty || bus.wr_valid;
    assign bypass_take  = empty && bus.wr_valid && bus.rd_ready;
`else
    assign bus.rd_valid = !empty;
    assign bypass_take  = 1'b0;
`endif

    assign bus.wr_ready = !full;
    assign push         = bus.wr_valid && !full;
    assign pop          = bus.rd_valid && bus.rd_ready;
    // A forwarded entry never touches storage, pointers or occupancy
    assign push_mem     = push && !bypass_take;
    assign pop_mem      = pop && !bypass_take;

    always_comb begin
        count_next = count_reg;
        if (push_mem && !pop_mem) begin
            count_next = count_reg + 1'b1;
        end else if (pop_mem && !push_mem) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hwm_reg    <= '0;
        end else begin
            if (push_mem) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_mem) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
            if (count_next > hwm_reg) begin
                hwm_reg <= count_next;
            end
        end
    end

    // Storage has no reset; stale words are hidden by the empty mask below
    always_ff @(posedge clk) begin
        if (push_mem) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    always_comb begin
        rot_src = '0;
        if (!empty) begin
            rot_src = entry_t'(mem[rd_ptr_reg]);
        end
`ifdef ELAB_LANE_FIFO_BYPASS_EN
        else if (bus.wr_valid) begin
            rot_src = bus.wr_data;
        end
`endif
    end

    // Out-of-range rotations fold back into 0..NLANES-1; a single lane always reads lane 0
    assign rot_amt = ROT_W'(int'(bus.rd_rot) % NLANES);

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_rot
        logic [ROT_W-1:0] src_idx;
        assign src_idx     = ROT_W'((gi + int'(rot_amt)) % NLANES);
        assign rot_out[gi] = rot_src[src_idx];
    end

    assign bus.rd_data = rot_out;
    assign count       = count_reg;
    assign hwm         = hwm_reg;
    assign cfg_word    = CFG_WORD;
endmodule

// File: tb/tb_elab_lane_fifo.sv
// Scoreboard bench for elab_lane_fifo: directed boundary cases then random traffic against a queue model.
module tb_elab_lane_fifo;
    localparam int LANE_W = 6;
    localparam int NLANES = 4;
    localparam int DEPTH  = 5;
    localparam int ROT_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [NLANES-1:0] entry_t;

    localparam entry_t ROT_SRC = {6'h3, 6'h2, 6'h1, 6'h0};
    localparam entry_t ROT1    = {6'h0, 6'h3, 6'h2, 6'h1};
    localparam entry_t ROT3    = {6'h2, 6'h1, 6'h0, 6'h3};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] hwm;
    logic [31:0]      cfg_word;

    elab_lane_fifo_if #(.LANE_W(LANE_W), .NLANES(NLANES)) bus ();

    elab_lane_fifo #(.LANE_W(LANE_W), .NLANES(NLANES), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .count    (count),
        .hwm      (hwm),
        .cfg_word (cfg_word)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     rd_valid;
        bit     wr_ready;
        int     count;
        int     hwm;
        entry_t head;
    } exp_t;

    exp_t   exp_q[$];
    entry_t model_q[$];
    int     model_hwm = 0;
    bit     pend_push = 0;
    bit     pend_pop  = 0;
    entry_t pend_data;
    int     checks = 0;
    int     passed = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endfunction

    function automatic entry_t rotate(entry_t e, int rot);
        entry_t r;
        for (int i = 0; i < NLANES; i++) r[i] = e[(i + rot) % NLANES];
        return r;
    endfunction

    // Apply the transfer decided last cycle, which the DUT performed on the edge just passed
    function automatic void commit();
        if (pend_pop) void'(model_q.pop_front());
        if (pend_push) model_q.push_back(pend_data);
        if (model_q.size() > model_hwm) model_hwm = model_q.size();
        pend_push = 0;
        pend_pop  = 0;
    endfunction

    function automatic void plan();
        int   n   = model_q.size();
        bit   byp = 0;
        exp_t e;
        e.count    = n;
        e.hwm      = model_hwm;
        e.wr_ready = (n < DEPTH);
        e.rd_valid = (n > 0);
        e.head     = '0;
        if (n > 0) e.head = model_q[0];
`ifdef ELAB_LANE_FIFO_BYPASS_EN
        if (n == 0 && bus.wr_valid) begin
            e.rd_valid = 1;
            e.head     = bus.wr_data;
            byp        = bus.rd_ready;
        end
`endif
        pend_push = bus.wr_valid && (n < DEPTH) && !byp;
        pend_pop  = bus.rd_ready && (n > 0);
        pend_data = bus.wr_data;
        exp_q.push_back(e);
    endfunction

    task automatic step(bit wv, entry_t wd, bit rr, int rot);
        @(posedge clk);
        #1;
        commit();
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        bus.rd_rot   = ROT_W'(rot);
        plan();
    endtask

    // Monitor: each cycle compares the DUT against the expectation queued when stimulus was issued
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 32'(count), 32'(e.count));
            chk("hwm", 32'(hwm), 32'(e.hwm));
            chk("wr_ready", 32'(bus.wr_ready), 32'(e.wr_ready));
            chk("rd_valid", 32'(bus.rd_valid), 32'(e.rd_valid));
            if (e.rd_valid) chk("rd_data", 32'(bus.rd_data), 32'(rotate(e.head, int'(bus.rd_rot))));
            else chk("rd_data_masked", 32'(bus.rd_data), 32'h0);
            if (bus.wr_valid && bus.wr_ready)
                $display("push data=%h count=%0d", bus.wr_data, count);
            if (bus.rd_valid && bus.rd_ready)
                $display("pop  data=%h rot=%0d count=%0d", bus.rd_data, bus.rd_rot, count);
        end
    end

    task automatic reset_mid();
        @(negedge clk);
        #2;
        chk("pre_reset_count", 32'(count), 32'(model_q.size()));
        bus.wr_valid = 0;
        bus.rd_ready = 0;
        rst = 1;
        #1;
        model_q.delete();
        model_hwm = 0;
        pend_push = 0;
        pend_pop  = 0;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
        chk("rst_hwm", 32'(hwm), 32'h0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
        chk("rst_cfg_word", cfg_word, 32'h0018_0504);
        // Handshakes held across an edge with reset high must not transfer
        bus.wr_valid = 1;
        bus.rd_ready = 1;
        bus.wr_data  = entry_t'(24'h123456);
        @(posedge clk);
        #1;
        chk("rst_edge_count", 32'(count), 32'h0);
        chk("rst_edge_hwm", 32'(hwm), 32'h0);
        bus.wr_valid = 0;
        bus.rd_ready = 0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wp;
        int rp;
        bus.wr_valid = 0;
        bus.wr_data  = '0;
        bus.rd_ready = 0;
        bus.rd_rot   = '0;
        #2;
        chk("init_count", 32'(count), 32'h0);
        chk("init_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("init_wr_ready", 32'(bus.wr_ready), 32'h1);
        chk("init_hwm", 32'(hwm), 32'h0);
        chk("init_cfg_word", cfg_word, 32'h0018_0504);
        repeat (2) @(negedge clk);
        rst = 0;

        for (int i = 1; i <= 3; i++) step(1, entry_t'(i), 0, 0);
        step(0, '0, 0, 0);
        reset_mid();

        // Fill to full, then exercise the blocked push and wrap-around
        for (int i = 1; i <= 5; i++) step(1, entry_t'(i), 0, 0);
        step(1, entry_t'(24'h3F3F3F), 1, 0);
        #1;
        chk("fill_count", 32'(count), 32'h5);
        chk("fill_hwm", 32'(hwm), 32'h5);
        chk("fill_wr_ready", 32'(bus.wr_ready), 32'h0);
        step(0, '0, 1, 0);
        step(1, entry_t'(6), 0, 0);
        step(1, entry_t'(7), 0, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, int'($urandom_range(0, (1 << ROT_W) - 1)));

        // Simultaneous push and pop at count 2
        step(1, entry_t'(8), 0, 0);
        step(1, entry_t'(9), 0, 0);
        step(1, entry_t'(10), 1, 1);
        step(0, '0, 1, 2);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Lane rotation of a known head entry
        step(1, ROT_SRC, 0, 0);
        step(0, '0, 0, 1);
        #2;
        chk("rot1", 32'(bus.rd_data), 32'(ROT1));
        step(0, '0, 0, 3);
        #2;
        chk("rot3", 32'(bus.rd_data), 32'(ROT3));
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Empty FIFO with push and pop requested together
        step(1, entry_t'(24'hABCDEF), 1, 0);
        #2;
`ifdef ELAB_LANE_FIFO_BYPASS_EN
        chk("byp_rd_valid", 32'(bus.rd_valid), 32'h1);
        chk("byp_rd_data", 32'(bus.rd_data), 32'hABCDEF);
`else
        chk("byp_rd_valid", 32'(bus.rd_valid), 32'h0);
`endif
        step(0, '0, 0, 0);
        #2;
`ifdef ELAB_LANE_FIFO_BYPASS_EN
        chk("byp_count_after", 32'(count), 32'h0);
`else
        chk("byp_count_after", 32'(count), 32'h1);
`endif
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Random traffic in fill-biased, drain-biased and balanced phases
        for (int k = 0; k < 600; k++) begin
            case ((k / 50) % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            step($urandom_range(0, 99) < wp, entry_t'($urandom),
                 $urandom_range(0, 99) < rp, int'($urandom_range(0, (1 << ROT_W) - 1)));
        end
        step(0, '0, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
